// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and the two's-complement sign-fix helper.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [63:0] neg_if(input logic [63:0] x, input logic s);
      return s ? (~x + 64'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring
// divide on unsigned magnitudes, sign fixed on the final step, one write-back beat.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; accepts operands and latches rd
// ST_CALC | one multiply/divide iteration per cycle, cnt 31 down to 0
// ST_DONE | wb_we high for one cycle, then back to ST_IDLE
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [AW-1:0]   rd_in,
   output logic            busy,
   output logic            wb_we,
   output logic [AW-1:0]   wb_addr,
   output logic [XLEN-1:0] result
);

   state_t            state;
   logic [2:0]        op_q;
   logic [AW-1:0]     rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   opr;
   logic [2*XLEN-1:0] acc;
   logic [4:0]        cnt;

   logic              is_div;
   logic [XLEN:0]     add_a, add_b, sum;
   logic [2*XLEN-1:0] acc_nx, fixed;
   logic [XLEN-1:0]   calc_res;

   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   ma, mb;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   spec_res;

   assign busy = (state != ST_IDLE);

   // One shared 33-bit adder: add the multiplicand, or subtract the divisor.
   always_comb begin
      is_div = op_q[2];
      add_a  = is_div ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
      add_b  = is_div ? ~{1'b0, opr} : (acc[0] ? {1'b0, opr} : '0);
      sum    = add_a + add_b + {{XLEN{1'b0}}, is_div};
      if (is_div)
         acc_nx = sum[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                            : {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nx = {sum, acc[XLEN-1:1]};
      if (is_div)
         fixed = neg_if({32'b0, op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0]}, neg_q);
      else
         fixed = neg_if(acc_nx, neg_q);
      calc_res = (!is_div && op_q != OP_MUL) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
   end

   always_comb begin
      a_signed = funct3[2] ? !funct3[0] : (funct3 != OP_MULHU);
      b_signed = funct3[2] ? !funct3[0] : !funct3[1];
      sa       = a_signed && op_a[XLEN-1];
      sb       = b_signed && op_b[XLEN-1];
      ma       = sa ? (~op_a + 1'b1) : op_a;
      mb       = sb ? (~op_b + 1'b1) : op_b;
      div_zero = funct3[2] && (op_b == '0);
      div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      if (div_zero)
         spec_res = funct3[1] ? op_a : '1;
      else
         spec_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         opr     <= '0;
         acc     <= '0;
         cnt     <= '0;
         wb_we   <= 1'b0;
         wb_addr <= '0;
         result  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb_we <= 1'b0;
               if (start) begin
                  op_q  <= funct3;
                  rd_q  <= rd_in;
                  neg_q <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
                  opr   <= funct3[2] ? mb : ma;
                  acc   <= {{XLEN{1'b0}}, funct3[2] ? ma : mb};
                  cnt   <= 5'd31;
                  if (div_zero || div_ovf) begin
                     result  <= spec_res;
                     wb_addr <= rd_in;
                     wb_we   <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_nx;
               if (cnt == 5'd0) begin
                  result  <= calc_res;
                  wb_addr <= rd_q;
                  wb_we   <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            ST_DONE: begin
               wb_we <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               wb_we <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus model-generated random ops,
// scoreboard of expected write-backs, and hand sequences for busy/reset corners.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] result;

   muldiv_unit #(.XLEN(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   wb_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Scoreboard consumer: every write-back beat must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && wb_we) begin
         wb_count++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got wb_we with addr %0d result 0x%08h expected none", wb_addr, result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("wb_result", result, e.res);
            check("wb_addr", {27'b0, wb_addr}, {27'b0, e.rd});
         end
      end
   end

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic signed [31:0] a32, b32;
      sa = $signed(a); sb = $signed(b);
      ua = $signed({32'b0, a}); ub = $signed({32'b0, b});
      a32 = $signed(a); b32 = $signed(b);
      p = '0;
      case (f)
         OP_MUL:    begin p = sa * sb; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV:    return a32 / b32;
         OP_DIVU:   return a / b;
         OP_REM:    return a32 % b32;
         default:   return a % b;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
      exp_t e;
      int n;
      @(negedge clk);
      start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
      e.res = exp; e.rd = rd;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      n = 1;
      while (!wb_we && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wb_latency", n, lat);
      @(negedge clk);
      check("busy_after", {31'b0, busy}, 32'd0);
      check("result_hold", result, exp);
   endtask

   vec_t vecs[20];

   initial begin
      vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[2]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
      vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
      vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        33};
      vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
      vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vecs[13] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
      vecs[14] = '{OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33};
      vecs[15] = '{OP_DIVU,   32'd3,        32'd10,       32'd0,        33};
      vecs[16] = '{OP_REMU,   32'd3,        32'd10,       32'd3,        33};
      vecs[17] = '{OP_DIV,    32'h80000000, 32'd1,        32'h80000000, 33};
      vecs[18] = '{OP_REM,    32'h80000000, 32'd3,        32'hFFFFFFFE, 33};
      vecs[19] = '{OP_DIVU,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};

      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_wb_we", {31'b0, wb_we}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++)
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat);

      run_op(OP_MUL, 32'd6, 32'd7, 5'd0, 32'd42, 33);

      for (int i = 0; i < 12; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom);
         a = $urandom;
         b = $urandom | 32'h1;
         if (f[2] && !f[0] && a == 32'h80000000) a = 32'h7FFFFFFF;
         run_op(f, a, b, 5'($urandom_range(1, 31)), model(f, a, b), 33);
      end

      // start pulses during CALC and in the DONE cycle must be ignored
      begin
         exp_t e;
         int base;
         base = wb_count;
         @(negedge clk);
         start = 1'b1; funct3 = OP_DIVU; op_a = 32'd1000; op_b = 32'd9; rd_in = 5'd9;
         e.res = 32'd111; e.rd = 5'd9;
         sb_q.push_back(e);
         for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 33);
            funct3 = OP_MUL; op_a = 32'd3; op_b = 32'd3; rd_in = 5'(c);
            if (c == 33) check("wb_we_cycle33", {31'b0, wb_we}, 32'd1);
         end
         start = 1'b0;
         repeat (40) @(negedge clk);
         check("single_wb", wb_count - base, 32'd1);
         check("busy_idle", {31'b0, busy}, 32'd0);
      end

      // asynchronous reset in cycle 12 aborts the operation without write-back
      begin
         exp_t e;
         int base;
         @(negedge clk);
         start = 1'b1; funct3 = OP_MUL; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd17;
         e.res = 32'd25; e.rd = 5'd17;
         sb_q.push_back(e);
         @(negedge clk);
         start = 1'b0;
         repeat (11) @(negedge clk);
         check("busy_before_rst", {31'b0, busy}, 32'd1);
         base = wb_count;
         rst_n = 1'b0;
         #1;
         check("arst_busy", {31'b0, busy}, 32'd0);
         check("arst_wb_we", {31'b0, wb_we}, 32'd0);
         check("arst_result", result, 32'd0);
         check("arst_wb_addr", {27'b0, wb_addr}, 32'd0);
         void'(sb_q.pop_back());
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (40) @(negedge clk);
         check("no_wb_after_rst", wb_count - base, 32'd0);
         run_op(OP_MULHU, 32'h00010000, 32'h00010000, 5'd4, 32'd1, 33);
      end

      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
